wb_serializer: RTL and testbench
================================

WB_SERIALIZER -- requirements
Module: wb_serializer

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, lanes per parallel result word.
REQ-002 SHALL have parameter DATA_W, default 16, FP16 lane width.
REQ-003 SHALL have parameter ADDR_W, default 30, DMA word-address width.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cfg_start  input  1  one-cycle pulse that arms a layer writeback.
REQ-007 SHALL have port cfg_base_addr  input  ADDR_W  first result address, sampled on cfg_start.
REQ-008 SHALL have port cfg_total_words  input  16  total words for the layer, sampled on cfg_start.
REQ-009 SHALL have port res_valid  input  1  engine offers a parallel result group.
REQ-010 SHALL have port res_ready  output  1  block accepts a result group.
REQ-011 SHALL have port res_data  input  BURST_LEN*DATA_W  lanes, lane 0 in bits [DATA_W-1:0].
REQ-012 SHALL have port res_count  input  5  number of valid lanes, starting from lane 0.
REQ-013 SHALL have port dma_p0_writes_en  output  1  write-burst request to DMA port 0.
REQ-014 SHALL have port p0_addr  output  ADDR_W  burst start address.
REQ-015 SHALL have port dma_p0_ib_re  input  1  DMA pops one word.
REQ-016 SHALL have port dma_p0_ib_data  output  DATA_W  serialized word.
REQ-017 SHALL have port dma_p0_ib_valid  output  1  dma_p0_ib_data is valid.
REQ-018 SHALL have port layer_done  output  1  one-cycle pulse when all words are sent.

Function
REQ-019 SHALL use the states IDLE, ARMED, WRITE and DONE.
REQ-020 SHALL move from IDLE to ARMED on cfg_start, latching base_addr into cur_addr and total_words, and clearing words_sent; cfg_start SHALL be ignored in any other state.
REQ-021 SHALL drive res_ready=1 only in ARMED; a group is transferred when res_valid and res_ready are both high.
REQ-022 SHALL, on a group transfer, latch all lanes into a buffer and latch the lane count (0 or above BURST_LEN clamps to BURST_LEN), set lane index to 0, and move to WRITE.
REQ-023 SHALL, in WRITE, hold dma_p0_writes_en=1 and p0_addr=cur_addr, both registered, on the cycle after entry.
REQ-024 SHALL, for each cycle in WRITE with dma_p0_ib_re=1, register buf[idx] into dma_p0_ib_data, assert dma_p0_ib_valid on the next cycle, and increment idx (one-cycle latency).
REQ-025 SHALL drive dma_p0_ib_valid=0 on any cycle without a pop; dma_p0_ib_re outside WRITE SHALL be ignored and no data SHALL be output.
REQ-026 SHALL, on the pop of the last lane (idx+1==count), deassert dma_p0_writes_en next cycle, add count to cur_addr (modulo 2^ADDR_W) and to words_sent, then go to DONE if the new words_sent is at least total_words, else to ARMED.
REQ-027 SHALL, in DONE, pulse layer_done for exactly one cycle and return to IDLE.
REQ-028 SHALL clamp a final group that exceeds the remaining words, sending only total_words-words_sent lanes.
REQ-029 SHALL, when cfg_total_words is 0, go from ARMED directly to DONE without accepting a group.

Reset
REQ-030 SHALL, on rst, force state IDLE, set all outputs to 0 (res_ready, dma_p0_writes_en, p0_addr, dma_p0_ib_data, dma_p0_ib_valid, layer_done), clear counters and buffer, and abort any burst in progress.

Configuration
REQ-031 SHALL, with macro WB_RELU_EN defined, output 16'h0000 for any lane whose sign bit is set at the moment of capture.
REQ-032 SHALL, without WB_RELU_EN, pass lanes through bit-exact.

Structure
REQ-033 SHALL take state encodings, DATA_W and BURST_LEN defaults from the shared engine package.
REQ-034 SHALL be a single module; an optional sub-module, wb_relu, MAY hold the per-lane clamp.

Verification
REQ-035 SHALL cover: base=0x100, total=16, one group of 16 lanes 0..15, re held high -> data 0..15 on 16 consecutive valid cycles, p0_addr=0x100, layer_done one cycle after the last word.
REQ-036 SHALL cover: total=20, groups of 16 then 4 -> second burst p0_addr=0x110 with 4 words, then layer_done.
REQ-037 SHALL cover: re toggled 1,0,1,0 -> valid follows re delayed by one cycle, with no lost or duplicated words.
REQ-038 SHALL cover: WB_RELU_EN defined, lane=16'hBC00 -> 16'h0000 output; undefined -> 16'hBC00 output.
REQ-039 SHALL cover: rst asserted after 5 words of a burst -> all outputs 0 immediately, IDLE, and a new cfg_start works normally.
REQ-040 SHALL cover: base=0x3FFF_FFF8, two bursts of 16 -> second p0_addr=0x0000_0008 (wrap); and total=0 -> layer_done with no writes_en.

Source files
------------

// File: rtl/wb_serializer_pkg.sv
// Shared engine package for the writeback serializer: lane geometry defaults
// and the FSM state encoding used by wb_serializer.
package wb_serializer_pkg;

  localparam int WB_BURST_LEN = 16;  // lanes per parallel result word
  localparam int WB_DATA_W    = 16;  // FP16 lane width
  localparam int WB_CFG_W     = 16;  // width of the per-layer word counters

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_t;

endpackage

// File: rtl/wb_relu.sv
// Per-lane output clamp for the writeback serializer.
// Build option: define WB_RELU_EN to zero every lane whose sign bit is set;
// without it the lane passes through bit-exact.
module wb_relu #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] lane_in,
  output logic [DATA_W-1:0] lane_out
);

`ifdef WB_RELU_EN
  // Negative FP16 values (sign bit set, including -0) are forced to +0.
  assign lane_out = lane_in[DATA_W-1] ? '0 : lane_in;
`else
  // Pass-through build: no modification of the lane.
  assign lane_out = lane_in;
`endif

endmodule

// File: rtl/wb_serializer.sv
// Writeback serializer: accepts parallel result groups from the compute
// engine and streams them lane by lane into DMA port 0 as write bursts,
// one burst per group, advancing the destination address after each burst.
// Build option: WB_RELU_EN enables the per-lane clamp inside wb_relu.
module wb_serializer
  import wb_serializer_pkg::*;
#(
  parameter int BURST_LEN = WB_BURST_LEN,
  parameter int DATA_W    = WB_DATA_W,
  parameter int ADDR_W    = 30
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_start,
  input  logic [ADDR_W-1:0]             cfg_base_addr,
  input  logic [15:0]                   cfg_total_words,
  input  logic                          res_valid,
  output logic                          res_ready,
  input  logic [BURST_LEN*DATA_W-1:0]   res_data,
  input  logic [4:0]                    res_count,
  output logic                          dma_p0_writes_en,
  output logic [ADDR_W-1:0]             p0_addr,
  input  logic                          dma_p0_ib_re,
  output logic [DATA_W-1:0]             dma_p0_ib_data,
  output logic                          dma_p0_ib_valid,
  output logic                          layer_done
);

  // Lane counter must be able to hold BURST_LEN itself; the buffer index
  // only needs to address lanes 0..BURST_LEN-1.
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  wb_state_t state_reg, state_next;

  logic [ADDR_W-1:0]  cur_addr_reg;
  logic [15:0]        total_reg;
  logic [15:0]        sent_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   idx_reg;
  logic [DATA_W-1:0]  buf_reg [BURST_LEN];
  logic [DATA_W-1:0]  lane_capt [BURST_LEN];

  logic               writes_en_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  data_reg;
  logic               valid_reg;
  logic               done_reg;

  logic [15:0]        grp_count;
  logic [15:0]        remain_words;
  logic [15:0]        take_words;
  logic [16:0]        sent_sum;
  logic               has_work;
  logic               xfer;
  logic               pop;
  logic               last_pop;
  logic               layer_complete;

  // Per-lane clamp applied to the incoming group before it is buffered.
  generate
    for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_lane
      wb_relu #(
        .DATA_W (DATA_W)
      ) u_relu (
        .lane_in  (res_data[gi*DATA_W +: DATA_W]),
        .lane_out (lane_capt[gi])
      );
    end
  endgenerate

  // Lane count of the offered group: 0 or anything beyond BURST_LEN means a
  // full group; then limited to what is still owed for this layer.
  always_comb begin
    grp_count = 16'(BURST_LEN);
    if (res_count != 5'd0 && 16'(res_count) <= 16'(BURST_LEN)) begin
      grp_count = 16'(res_count);
    end
    remain_words = total_reg - sent_reg;
    take_words   = (grp_count < remain_words) ? grp_count : remain_words;
  end

  assign has_work       = (sent_reg < total_reg);
  assign res_ready      = (state_reg == ST_ARMED) && has_work;
  assign xfer           = res_valid && res_ready;
  assign pop            = (state_reg == ST_WRITE) && dma_p0_ib_re;
  assign last_pop       = pop && ((idx_reg + CNT_W'(1)) == count_reg);
  assign sent_sum       = {1'b0, sent_reg} + 17'(count_reg);
  assign layer_complete = (sent_sum >= {1'b0, total_reg});

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: arm on start, write one burst per accepted group,
  // finish once the layer's word budget is used up.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_start) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (!has_work)      state_next = ST_DONE;
        else if (res_valid) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (last_pop) state_next = layer_complete ? ST_DONE : ST_ARMED;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Layer bookkeeping: base address, word budget and progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr_reg <= '0;
      total_reg    <= '0;
      sent_reg     <= '0;
    end else if (state_reg == ST_IDLE && cfg_start) begin
      cur_addr_reg <= cfg_base_addr;
      total_reg    <= cfg_total_words;
      sent_reg     <= '0;
    end else if (last_pop) begin
      cur_addr_reg <= cur_addr_reg + ADDR_W'(count_reg);
      sent_reg     <= sent_sum[15:0];
    end
  end

  // Group capture buffer and lane bookkeeping for the current burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        buf_reg[i] <= '0;
      end
      count_reg <= '0;
      idx_reg   <= '0;
    end else if (xfer) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        buf_reg[i] <= lane_capt[i];
      end
      count_reg <= CNT_W'(take_words);
      idx_reg   <= '0;
    end else if (pop) begin
      idx_reg <= idx_reg + CNT_W'(1);
    end
  end

  // DMA burst request: raised with the burst address when a group is taken,
  // dropped after the final lane has been popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      writes_en_reg <= 1'b0;
      addr_reg      <= '0;
    end else if (xfer) begin
      writes_en_reg <= 1'b1;
      addr_reg      <= cur_addr_reg;
    end else if (last_pop) begin
      writes_en_reg <= 1'b0;
    end
  end

  // Serialized output word, one cycle behind each pop; valid only on pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= pop;
      if (pop) begin
        data_reg <= buf_reg[idx_reg[IDX_W-1:0]];
      end
    end
  end

  // Layer completion pulse, one cycle for each visit to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == ST_DONE);
    end
  end

  assign dma_p0_writes_en = writes_en_reg;
  assign p0_addr          = addr_reg;
  assign dma_p0_ib_data   = data_reg;
  assign dma_p0_ib_valid  = valid_reg;
  assign layer_done       = done_reg;

endmodule

// File: tb/tb_wb_serializer.sv
// Self-checking bench for wb_serializer: a table of layer scenarios driven
// through a common task, a word/address scoreboard fed when groups are
// offered and drained by a negedge monitor, plus a mid-burst reset sequence.
module tb_wb_serializer;

  localparam int BL = 16;
  localparam int DW = 16;
  localparam int AW = 30;
  localparam int NV = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_start = 1'b0;
  logic [AW-1:0]     cfg_base_addr = '0;
  logic [15:0]       cfg_total_words = '0;
  logic              res_valid = 1'b0;
  logic              res_ready;
  logic [BL*DW-1:0]  res_data = '0;
  logic [4:0]        res_count = '0;
  logic              dma_p0_writes_en;
  logic [AW-1:0]     p0_addr;
  logic              dma_p0_ib_re = 1'b0;
  logic [DW-1:0]     dma_p0_ib_data;
  logic              dma_p0_ib_valid;
  logic              layer_done;

  wb_serializer #(
    .BURST_LEN (BL),
    .DATA_W    (DW),
    .ADDR_W    (AW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_start        (cfg_start),
    .cfg_base_addr    (cfg_base_addr),
    .cfg_total_words  (cfg_total_words),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_count        (res_count),
    .dma_p0_writes_en (dma_p0_writes_en),
    .p0_addr          (p0_addr),
    .dma_p0_ib_re     (dma_p0_ib_re),
    .dma_p0_ib_data   (dma_p0_ib_data),
    .dma_p0_ib_valid  (dma_p0_ib_valid),
    .layer_done       (layer_done)
  );

  always #5 clk = ~clk;

  // One layer scenario with its expected outcome.
  typedef struct {
    logic [AW-1:0] base;
    logic [15:0]   total;
    int            ngroups;
    logic [4:0]    cnt0;
    logic [4:0]    cnt1;
    logic [15:0]   seed;
    int            re_mode;     // 0: re held high, 1: re toggles every cycle
    int            poke;        // pulse cfg_start during the first burst
    int            exp_words;
    int            exp_bursts;
    logic [AW-1:0] exp_a0;
    logic [AW-1:0] exp_a1;
  } vec_t;

  vec_t vecs [NV];

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] addr_q [$];

  int   cyc = 0;
  int   words_seen = 0;
  int   burst_count = 0;
  int   done_count = 0;
  int   last_valid_cyc = -100;
  int   expect_words_layer = 0;
  int   re_mode = 0;
  logic done_prev = 1'b0;
  logic wen_prev = 1'b0;
  logic re_seen = 1'b0;

  function automatic logic [DW-1:0] relu_model(input logic [DW-1:0] v);
`ifdef WB_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Read-enable driver.
  initial begin
    forever begin
      @(negedge clk);
      if (re_mode == 1) dma_p0_ib_re = ~dma_p0_ib_re;
      else              dma_p0_ib_re = 1'b1;
    end
  end

  // Output monitor: words against the scoreboard, burst addresses, done pulse.
  initial begin
    forever begin
      @(posedge clk);
      re_seen = dma_p0_ib_re;
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (dma_p0_ib_valid) begin
          check("valid_follows_re", re_seen, 1);
          if (exp_q.size() == 0) begin
            total_cnt++;
            bad_cnt++;
            $display("FAIL unexpected_word: got 0x%0h with no word expected", dma_p0_ib_data);
          end else begin
            check("word", dma_p0_ib_data, exp_q.pop_front());
          end
          words_seen++;
          last_valid_cyc = cyc;
        end
        if (dma_p0_writes_en && !wen_prev) begin
          burst_count++;
          if (addr_q.size() == 0) begin
            total_cnt++;
            bad_cnt++;
            $display("FAIL unexpected_burst: p0_addr 0x%0h with no burst expected", p0_addr);
          end else begin
            check("p0_addr", p0_addr, addr_q.pop_front());
          end
        end
        if (layer_done) begin
          done_count++;
          check("done_width", done_prev, 0);
          if (expect_words_layer > 0) check("done_after_last_word", cyc - last_valid_cyc, 1);
        end
        done_prev = layer_done;
        wen_prev  = dma_p0_writes_en;
      end else begin
        done_prev = 1'b0;
        wen_prev  = 1'b0;
      end
    end
  end

  task automatic pulse_start(input logic [AW-1:0] base, input logic [15:0] total);
    cfg_base_addr   = base;
    cfg_total_words = total;
    cfg_start       = 1'b1;
    @(negedge clk);
    cfg_start       = 1'b0;
  endtask

  // Offer one group and push the words the DUT is expected to emit for it.
  task automatic offer_group(input string tag, input logic [15:0] first, input logic [4:0] cnt,
                             input int take);
    logic [BL*DW-1:0] data;
    int k;
    for (int i = 0; i < BL; i++) data[i*DW +: DW] = first + 16'(i);
    res_data  = data;
    res_count = cnt;
    res_valid = 1'b1;
    k = 0;
    while (!res_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready"}, res_ready, 1);
    for (int i = 0; i < take; i++) exp_q.push_back(relu_model(data[i*DW +: DW]));
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic run_layer(input vec_t v, input int id);
    int b0, d0, w0, k, sent, eff, rem, take;
    logic [4:0] cnt;
    string tag;
    b0 = burst_count;
    d0 = done_count;
    w0 = words_seen;
    if (v.exp_bursts > 0) addr_q.push_back(v.exp_a0);
    if (v.exp_bursts > 1) addr_q.push_back(v.exp_a1);
    expect_words_layer = v.exp_words;
    re_mode = v.re_mode;
    pulse_start(v.base, v.total);
    repeat (2) @(negedge clk);
    sent = 0;
    for (int g = 0; g < v.ngroups; g++) begin
      cnt  = (g == 0) ? v.cnt0 : v.cnt1;
      eff  = (cnt == 5'd0 || int'(cnt) > BL) ? BL : int'(cnt);
      rem  = int'(v.total) - sent;
      take = (eff < rem) ? eff : rem;
      tag  = $sformatf("v%0d_g%0d", id, g);
      offer_group(tag, v.seed + 16'(g * BL), cnt, take);
      if (v.poke != 0 && g == 0) pulse_start(30'h777, 16'd1);
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
        @(negedge clk);
        k++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
      sent += take;
    end
    k = 0;
    while (done_count == d0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check($sformatf("v%0d_done_pulses", id), done_count - d0, 1);
    check($sformatf("v%0d_bursts", id), burst_count - b0, v.exp_bursts);
    check($sformatf("v%0d_words", id), words_seen - w0, v.exp_words);
    check($sformatf("v%0d_addr_left", id), addr_q.size(), 0);
    $display("layer %0d: base=0x%0h total=%0d words=%0d bursts=%0d", id, v.base, v.total,
             words_seen - w0, burst_count - b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_res_ready"}, res_ready, 0);
    check({tag, "_writes_en"}, dma_p0_writes_en, 0);
    check({tag, "_p0_addr"}, p0_addr, 0);
    check({tag, "_ib_data"}, dma_p0_ib_data, 0);
    check({tag, "_ib_valid"}, dma_p0_ib_valid, 0);
    check({tag, "_layer_done"}, layer_done, 0);
  endtask

  // Reset five words into a burst, then prove a fresh layer still works.
  task automatic reset_mid_burst();
    int w0, k;
    re_mode = 0;
    w0 = words_seen;
    addr_q.push_back(30'h500);
    expect_words_layer = 16;
    pulse_start(30'h500, 16'd16);
    repeat (2) @(negedge clk);
    offer_group("rst_g0", 16'h0100, 5'd16, 16);
    k = 0;
    while ((words_seen - w0) < 5 && k < 100) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("rst_words_before", words_seen - w0, 5);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle_ready", res_ready, 0);
    $display("reset mid-burst after %0d words", words_seen - w0);
    run_layer(vecs[0], 99);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // base, total, ngroups, cnt0, cnt1, seed, re_mode, poke, exp_words, exp_bursts, exp_a0, exp_a1
    vecs[0] = '{30'h100,       16'd16, 1, 5'd16, 5'd0,  16'h0000, 0, 0, 16, 1, 30'h100,       30'h0};
    vecs[1] = '{30'h100,       16'd20, 2, 5'd16, 5'd4,  16'h1000, 0, 1, 20, 2, 30'h100,       30'h110};
    vecs[2] = '{30'h200,       16'd8,  1, 5'd8,  5'd0,  16'hBBFC, 1, 0, 8,  1, 30'h200,       30'h0};
    vecs[3] = '{30'h3FFFFFF8,  16'd32, 2, 5'd16, 5'd16, 16'h7FF8, 0, 0, 32, 2, 30'h3FFFFFF8,  30'h8};
    vecs[4] = '{30'h300,       16'd0,  0, 5'd0,  5'd0,  16'h0000, 0, 0, 0,  0, 30'h0,         30'h0};
    vecs[5] = '{30'h40,        16'd10, 1, 5'd0,  5'd0,  16'h0050, 1, 0, 10, 1, 30'h40,        30'h0};
    vecs[6] = '{30'h80,        16'd5,  1, 5'd20, 5'd0,  16'hFFFE, 0, 0, 5,  1, 30'h80,        30'h0};

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", res_ready, 0);

    for (int i = 0; i < NV; i++) run_layer(vecs[i], i);

    reset_mid_burst();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
